pll_power_sequencer: RTL and testbench



---
 rtl/pll_power_sequencer.sv | 161 ++++++++++++++++
 tb/tb_pll_power_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_power_sequencer.sv
// Power and clock sequencer for the JPEG PLL: brings the PLL up, waits for stable lock,
// hands the image buffer to the JPEG clock, and drains/powers down on CSR request.
module pll_power_sequencer #(
    parameter int unsigned SETTLE_CYCLES        = 16,
    parameter int unsigned RESET_HOLD_CYCLES    = 8,
    parameter int unsigned LOCK_STABLE_CYCLES   = 256,
    parameter int unsigned LOCK_TIMEOUT_CYCLES  = 65535,
    parameter int unsigned DRAIN_TIMEOUT_CYCLES = 4096
) (
    input  logic       clock_in,
    input  logic       reset_in,
    input  logic       power_down_request_in,
    input  logic       pll_locked_in,
    input  logic       jpeg_busy_in,
    output logic       pllpowerdown_n_out,
    output logic       pll_reset_out,
    output logic       image_buffer_read_en_out,
    output logic       jpeg_clock_ready_out,
    output logic [3:0] state_out,
    output logic       lock_error_out,
    output logic [3:0] retry_count_out
);

    typedef enum logic [3:0] {
        RESET_HOLD     = 4'd0,
        WAIT_LOCK      = 4'd1,
        SWITCH_TO_JPEG = 4'd2,
        RUN            = 4'd3,
        DRAIN          = 4'd4,
        SWITCH_TO_SPI  = 4'd5,
        POWER_DOWN     = 4'd6,
        OFF            = 4'd7
    } state_t;

    localparam logic [15:0] SETTLE_LD  = 16'(SETTLE_CYCLES);
    localparam logic [15:0] HOLD_LD    = 16'(RESET_HOLD_CYCLES);
    localparam logic [15:0] STABLE_LD  = 16'(LOCK_STABLE_CYCLES);
    localparam logic [15:0] TIMEOUT_LD = 16'(LOCK_TIMEOUT_CYCLES);
    localparam logic [15:0] DRAIN_LD   = 16'(DRAIN_TIMEOUT_CYCLES);

    // Value the shared down-counter takes when a state is entered; RUN and OFF are untimed.
    function automatic logic [15:0] load_value(input state_t s);
        case (s)
            RESET_HOLD:     load_value = HOLD_LD;
            WAIT_LOCK:      load_value = TIMEOUT_LD;
            SWITCH_TO_JPEG: load_value = SETTLE_LD;
            DRAIN:          load_value = DRAIN_LD;
            SWITCH_TO_SPI:  load_value = SETTLE_LD;
            POWER_DOWN:     load_value = SETTLE_LD;
            default:        load_value = 16'd0;
        endcase
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        sat_inc = (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Synchronizer stages, bit order {request, locked, busy}
    logic [2:0]  sync_p0, sync_p1;
    logic        req_s, lock_s, busy_s;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [15:0] stab_cnt, stab_nxt;
    logic        expired;
    logic        err_nxt;
    logic [3:0]  retry_nxt;
    logic        pdn_nxt, prst_nxt, rden_nxt, rdy_nxt;

    assign req_s   = sync_p1[2];
    assign lock_s  = sync_p1[1];
    assign busy_s  = sync_p1[0];
    // A timed state leaves on the edge where its counter reaches zero, so it lasts exactly N cycles.
    assign expired = (cnt <= 16'd1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt != 16'd0) ? cnt - 16'd1 : cnt;
        stab_nxt  = stab_cnt;
        err_nxt   = lock_error_out;
        retry_nxt = retry_count_out;
        case (state)
            RESET_HOLD: if (expired) state_nxt = WAIT_LOCK;
            WAIT_LOCK: begin
                if (!lock_s)
                    stab_nxt = STABLE_LD;
                else if (stab_cnt <= 16'd1)
                    state_nxt = SWITCH_TO_JPEG;
                else
                    stab_nxt = stab_cnt - 16'd1;
                if (state_nxt == WAIT_LOCK && expired) begin
                    err_nxt   = 1'b1;
                    retry_nxt = sat_inc(retry_count_out);
                    state_nxt = RESET_HOLD;
                end
            end
            SWITCH_TO_JPEG: if (expired) state_nxt = RUN;
            RUN: begin
                if (!lock_s) begin
                    err_nxt   = 1'b1;
                    state_nxt = RESET_HOLD;
                end else if (req_s) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!req_s)
                    state_nxt = RUN;
                else if (!busy_s || expired)
                    state_nxt = SWITCH_TO_SPI;
            end
            SWITCH_TO_SPI: if (expired) state_nxt = POWER_DOWN;
            POWER_DOWN:    if (expired) state_nxt = OFF;
            OFF:           if (!req_s) state_nxt = RESET_HOLD;
            default:       state_nxt = RESET_HOLD;
        endcase
        if (state_nxt != state) begin
            cnt_nxt  = load_value(state_nxt);
            stab_nxt = STABLE_LD;
        end
    end

    // Outputs are decoded from the next state and registered, so they line up with state_out.
    always_comb begin
        pdn_nxt  = !(state_nxt == POWER_DOWN || state_nxt == OFF);
        prst_nxt = (state_nxt == RESET_HOLD || state_nxt == POWER_DOWN || state_nxt == OFF);
        rden_nxt = !(state_nxt == SWITCH_TO_JPEG || state_nxt == RUN || state_nxt == DRAIN);
        rdy_nxt  = (state_nxt == RUN);
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            sync_p0                  <= 3'b000;
            sync_p1                  <= 3'b000;
            state                    <= RESET_HOLD;
            cnt                      <= HOLD_LD;
            stab_cnt                 <= STABLE_LD;
            lock_error_out           <= 1'b0;
            retry_count_out          <= 4'd0;
            pllpowerdown_n_out       <= 1'b1;
            pll_reset_out            <= 1'b1;
            image_buffer_read_en_out <= 1'b1;
            jpeg_clock_ready_out     <= 1'b0;
        end else begin
            sync_p0                  <= {power_down_request_in, pll_locked_in, jpeg_busy_in};
            sync_p1                  <= sync_p0;
            state                    <= state_nxt;
            cnt                      <= cnt_nxt;
            stab_cnt                 <= stab_nxt;
            lock_error_out           <= err_nxt;
            retry_count_out          <= retry_nxt;
            pllpowerdown_n_out       <= pdn_nxt;
            pll_reset_out            <= prst_nxt;
            image_buffer_read_en_out <= rden_nxt;
            jpeg_clock_ready_out     <= rdy_nxt;
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_pll_power_sequencer.sv
// Scoreboard bench for pll_power_sequencer: a cycle-level reference model predicts every
// output vector, directed phases cover the key sequences, then randomized segments follow.
module tb_pll_power_sequencer;

    localparam int H = 3;
    localparam int L = 10;
    localparam int T = 40;
    localparam int S = 4;
    localparam int D = 30;

    logic       clk = 1'b1;
    logic       rst;
    logic       req, lock, busy;
    logic       pdn, prst, rden, rdy, err;
    logic [3:0] st, retry;

    pll_power_sequencer #(
        .SETTLE_CYCLES(S), .RESET_HOLD_CYCLES(H), .LOCK_STABLE_CYCLES(L),
        .LOCK_TIMEOUT_CYCLES(T), .DRAIN_TIMEOUT_CYCLES(D)
    ) dut (
        .clock_in(clk), .reset_in(rst), .power_down_request_in(req),
        .pll_locked_in(lock), .jpeg_busy_in(busy),
        .pllpowerdown_n_out(pdn), .pll_reset_out(prst),
        .image_buffer_read_en_out(rden), .jpeg_clock_ready_out(rdy),
        .state_out(st), .lock_error_out(err), .retry_count_out(retry)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pdn, prst, rden, rdy, err;
        logic [3:0] retry;
    } obs_t;

    obs_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: state index, cycles already spent in it, consecutive-lock run,
    // and the two-cycle input delay of the synchronizers.
    int m_st, m_e, m_run, m_retry;
    bit m_err;
    bit d1_req, d1_lock, d1_busy, d2_req, d2_lock, d2_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic obs_t m_out();
        obs_t o;
        o.st    = 4'(m_st);
        o.pdn   = !(m_st == 6 || m_st == 7);
        o.prst  = (m_st == 0 || m_st == 6 || m_st == 7);
        o.rden  = !(m_st == 2 || m_st == 3 || m_st == 4);
        o.rdy   = (m_st == 3);
        o.err   = m_err;
        o.retry = 4'(m_retry);
        return o;
    endfunction

    task automatic model_reset();
        m_st = 0; m_e = 0; m_run = 0; m_retry = 0; m_err = 0;
        {d1_req, d1_lock, d1_busy, d2_req, d2_lock, d2_busy} = '0;
    endtask

    task automatic model_step(input bit r, input bit rq, input bit lk, input bit bz);
        int nx;
        if (r) begin
            model_reset();
            return;
        end
        nx = m_st;
        case (m_st)
            0: if (m_e + 1 >= H) nx = 1;
            1: begin
                m_run = d2_lock ? m_run + 1 : 0;
                if (m_run >= L) nx = 2;
                else if (m_e + 1 >= T) begin
                    m_err = 1; m_retry = (m_retry < 15) ? m_retry + 1 : 15; nx = 0;
                end
            end
            2: if (m_e + 1 >= S) nx = 3;
            3: if (!d2_lock) begin m_err = 1; nx = 0; end
               else if (d2_req) nx = 4;
            4: if (!d2_req) nx = 3;
               else if (!d2_busy || m_e + 1 >= D) nx = 5;
            5: if (m_e + 1 >= S) nx = 6;
            6: if (m_e + 1 >= S) nx = 7;
            default: if (!d2_req) nx = 0;
        endcase
        {d2_req, d2_lock, d2_busy} = {d1_req, d1_lock, d1_busy};
        {d1_req, d1_lock, d1_busy} = {rq, lk, bz};
        if (nx != m_st) begin m_st = nx; m_e = 0; m_run = 0; end
        else m_e++;
    endtask

    // One clock of stimulus: drive on the falling edge, queue the prediction for the next rising edge.
    task automatic cyc(input bit r, input bit rq, input bit lk, input bit bz);
        @(negedge clk);
        rst = r; req = rq; lock = lk; busy = bz;
        model_step(r, rq, lk, bz);
        sb.push_back(m_out());
    endtask

    task automatic reset_async_check(input string name);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk({name, "_pdn_n"}, 32'(pdn), 32'd1);
        chk({name, "_pll_reset"}, 32'(prst), 32'd1);
        model_step(1'b1, req, lock, busy);
        sb.push_back(m_out());
    endtask

    initial begin : monitor
        obs_t act, exp;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL sb_empty: no prediction queued at %0t", $time);
            end else begin
                exp = sb.pop_front();
                act = {st, pdn, prst, rden, rdy, err, retry};
                chk("outputs{st,pdn,rst,rden,rdy,err,retry}", 32'(act), 32'(exp));
            end
        end
    end

    initial begin : stimulus
        int len;
        int mode;
        rst = 1'b1; req = 1'b0; lock = 1'b0; busy = 1'b0;
        model_reset();
        repeat (4) cyc(1, 0, 0, 0);
        chk("reset_state", 32'(st), 32'd0);
        chk("reset_rden", 32'(rden), 32'd1);

        // Power-on with lock already present
        repeat (40) cyc(0, 0, 1, 1'($urandom_range(0, 1)));
        chk("poweron_ready", 32'(rdy), 32'd1);
        chk("poweron_state", 32'(st), 32'd3);

        // Drain with busy, then power down to OFF
        repeat (20) cyc(0, 1, 1, 1);
        chk("drain_hold", 32'(st), 32'd4);
        repeat (50) cyc(0, 1, 1, 0);
        chk("off_state", 32'(st), 32'd7);
        chk("off_rden", 32'(rden), 32'd1);

        // Leave OFF, relock, then abort a drain
        repeat (40) cyc(0, 0, 1, 1);
        repeat (10) cyc(0, 1, 1, 1);
        repeat (10) cyc(0, 0, 1, 1);
        chk("abort_state", 32'(st), 32'd3);

        // Drain timeout with busy stuck high
        repeat (60) cyc(0, 1, 1, 1);
        chk("drain_timeout_off", 32'(st), 32'd7);

        reset_async_check("reset_in_off");
        cyc(1, 1, 1, 1);
        repeat (40) cyc(0, 0, 1, 0);
        chk("relock_after_reset", 32'(st), 32'd3);

        // Single-cycle lock drop in RUN
        cyc(0, 0, 0, 0);
        repeat (40) cyc(0, 0, 1, 0);
        chk("lockloss_err", 32'(err), 32'd1);
        chk("lockloss_relock", 32'(st), 32'd3);

        // Lock never arrives: retries saturate
        repeat (800) cyc(0, 0, 0, 0);
        chk("retry_saturated", 32'(retry), 32'd15);

        repeat (2) cyc(1, 0, 0, 0);
        chk("err_cleared_by_reset", 32'(err), 32'd0);

        for (int seg = 0; seg < 60; seg++) begin
            mode = $urandom_range(0, 4);
            case (mode)
                0: begin
                    len = $urandom_range(20, 60);
                    for (int i = 0; i < len; i++)
                        cyc(0, 1'($urandom_range(0, 7) == 0), 1, 1'($urandom_range(0, 1)));
                end
                1: begin
                    cyc(0, 0, 0, 0);
                    repeat (30) cyc(0, 0, 1, 1'($urandom_range(0, 1)));
                end
                2: begin
                    len = $urandom_range(30, 100);
                    repeat (len) cyc(0, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)));
                end
                3: begin
                    len = $urandom_range(40, 80);
                    repeat (len) cyc(0, 1, 1, 1'($urandom_range(0, 3) != 0));
                    repeat (30) cyc(0, 0, 1, 0);
                end
                default: begin
                    if (m_st == 7) reset_async_check("reset_in_off_rand");
                    else cyc(1, 0, 1, 0);
                    cyc(1, 0, 1, 0);
                    repeat (20) cyc(0, 0, 1, 0);
                end
            endcase
        end

        @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
